// File: rtl/scan_seq_multi.sv
// scan_seq_multi: table-driven phase sequencer for the NMR analogue front-end controls.
// Define SCAN_ALT_ACQ_EN to rotate the acquisition-switch bits by scan number (phase cycling).
module scan_seq_multi #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NCH    = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_sys,
  input  logic              scanrst,
  input  logic              scanstart,
  input  logic              scanabort,
  input  logic              scanload,
  input  logic              scanchoice,
  input  logic              tbl_clr,
  input  logic [DATA_W-1:0] datain,
  output logic              interrupt,
  output logic              busy,
  output logic              load_err,
  output logic [CNT_W-1:0]  scan_cnt,
  output logic              dumpon_ctr,
  output logic              dumpoff_ctr,
  output logic              rt_sw,
  output logic              calctrl,
  output logic              soft_d,
  output logic              s_acq,
  output logic              dds_conf,
  output logic [NCH-1:0]    sw_acq
);

  localparam int unsigned PAT_W  = 7 + NCH;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WP_W   = $clog2(2 * DEPTH + 1);
  localparam int unsigned WP_END = 2 * DEPTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic              start_q;
  logic [WP_W-1:0]   wr_ptr;
  logic [DATA_W-1:0] dur [DEPTH];
  logic [PAT_W-1:0]  pat [DEPTH];
  logic [CNT_W-1:0]  rep;
  logic [IDX_W-1:0]  phase;
  logic [DATA_W-1:0] cyc;
  logic [PAT_W-1:0]  pat_q;

  logic              start_rise;
  logic              at_last;
  logic              scan_end;
  logic              seq_done;
  logic [IDX_W-1:0]  nxt_idx;
  logic [IDX_W-1:0]  ld_idx;
  logic [CNT_W-1:0]  cnt_inc;
  logic [PAT_W-1:0]  ld_pat;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_ok;

  // Phase-end decision: a zero duration or the last table slot closes the scan.
  always_comb begin
    start_rise = scanstart & ~start_q;
    at_last    = (phase == IDX_W'(DEPTH - 1));
    nxt_idx    = at_last ? '0 : phase + IDX_W'(1);
    scan_end   = at_last || (dur[nxt_idx] == '0);
    cnt_inc    = scan_cnt + CNT_W'(1);
    seq_done   = scan_end && (rep != '0) && (cnt_inc == rep);
    ld_idx     = ((state == RUN) && !scan_end) ? nxt_idx : '0;
  end

`ifdef SCAN_ALT_ACQ_EN
  logic [CNT_W-1:0] ld_cnt;
  logic [2*NCH-1:0] sw_dbl;

  // Pattern about to be shown, with switch bits rotated by the scan it belongs to.
  always_comb begin
    ld_cnt = '0;
    if (state == RUN) ld_cnt = scan_end ? cnt_inc : scan_cnt;
    sw_dbl = {pat[ld_idx][PAT_W-1:7], pat[ld_idx][PAT_W-1:7]} << (ld_cnt % CNT_W'(NCH));
    ld_pat = {sw_dbl[2*NCH-1:NCH], pat[ld_idx][6:0]};
  end
`else
  assign ld_pat = pat[ld_idx];
`endif

  assign wr_idx = IDX_W'(wr_ptr >> 1);
  assign wr_ok  = scanload && !scanchoice && !tbl_clr && (state == IDLE) &&
                  (wr_ptr != WP_W'(WP_END));

  // Pattern words are not cleared by reset or tbl_clr.
  always_ff @(posedge clk_sys) begin
    if (scanrst && wr_ok && wr_ptr[0]) pat[wr_idx] <= datain[PAT_W-1:0];
  end

  always_ff @(posedge clk_sys) begin
    if (!scanrst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      wr_ptr    <= '0;
      rep       <= CNT_W'(1);
      phase     <= '0;
      cyc       <= '0;
      pat_q     <= '0;
      scan_cnt  <= '0;
      interrupt <= 1'b0;
      load_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) dur[i] <= '0;
    end else begin
      start_q   <= scanstart;
      interrupt <= 1'b0;

      // Table and repeat register writes are only accepted while idle.
      if (state == RUN) begin
        if (scanload || tbl_clr) load_err <= 1'b1;
      end else if (tbl_clr) begin
        wr_ptr <= '0;
        for (int i = 0; i < DEPTH; i++) dur[i] <= '0;
      end else if (scanload) begin
        if (scanchoice) begin
          rep <= CNT_W'(datain);
        end else if (wr_ptr == WP_W'(WP_END)) begin
          load_err <= 1'b1;
        end else begin
          if (!wr_ptr[0]) dur[wr_idx] <= datain;
          wr_ptr <= wr_ptr + WP_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start_rise && !scanabort) begin
            if (dur[0] != '0) begin
              state    <= RUN;
              scan_cnt <= '0;
              phase    <= '0;
              cyc      <= dur[0];
              pat_q    <= ld_pat;
            end else begin
              load_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (scanabort) begin
            state <= IDLE;
            pat_q <= '0;
          end else if (cyc != DATA_W'(1)) begin
            cyc <= cyc - DATA_W'(1);
          end else if (!scan_end) begin
            phase <= nxt_idx;
            cyc   <= dur[nxt_idx];
            pat_q <= ld_pat;
          end else begin
            scan_cnt <= cnt_inc;
            if (seq_done) begin
              state     <= IDLE;
              pat_q     <= '0;
              interrupt <= 1'b1;
            end else begin
              phase <= '0;
              cyc   <= dur[0];
              pat_q <= ld_pat;
            end
          end
        end
      endcase
    end
  end

  assign busy        = (state == RUN);
  assign dumpon_ctr  = pat_q[0];
  assign dumpoff_ctr = pat_q[1];
  assign rt_sw       = pat_q[2];
  assign calctrl     = pat_q[3];
  assign soft_d      = pat_q[4];
  assign s_acq       = pat_q[5];
  assign dds_conf    = pat_q[6];
  assign sw_acq      = pat_q[PAT_W-1:7];

endmodule

// File: tb/tb_scan_seq_multi.sv
// Self-checking bench for scan_seq_multi: expected output traces are expanded from the table contents.
module tb_scan_seq_multi;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NCH    = 2;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PAT_W  = 7 + NCH;

  logic              clk_sys = 1'b0;
  logic              scanrst, scanstart, scanabort, scanload, scanchoice, tbl_clr;
  logic [DATA_W-1:0] datain;
  logic              interrupt, busy, load_err;
  logic [CNT_W-1:0]  scan_cnt;
  logic              dumpon_ctr, dumpoff_ctr, rt_sw, calctrl, soft_d, s_acq, dds_conf;
  logic [NCH-1:0]    sw_acq;
  logic [PAT_W-1:0]  obs;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_dur [DEPTH];
  logic [PAT_W-1:0]  m_pat [DEPTH];
  int                m_ptr;
  logic [CNT_W-1:0]  m_rep;
  bit                m_err;
  logic [PAT_W-1:0]  trace [$];
  int                scan_len;

  scan_seq_multi #(.DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_sys(clk_sys), .scanrst(scanrst), .scanstart(scanstart), .scanabort(scanabort),
    .scanload(scanload), .scanchoice(scanchoice), .tbl_clr(tbl_clr), .datain(datain),
    .interrupt(interrupt), .busy(busy), .load_err(load_err), .scan_cnt(scan_cnt),
    .dumpon_ctr(dumpon_ctr), .dumpoff_ctr(dumpoff_ctr), .rt_sw(rt_sw), .calctrl(calctrl),
    .soft_d(soft_d), .s_acq(s_acq), .dds_conf(dds_conf), .sw_acq(sw_acq)
  );

  always #5 clk_sys = ~clk_sys;

  assign obs = {sw_acq, dds_conf, s_acq, soft_d, calctrl, rt_sw, dumpoff_ctr, dumpon_ctr};

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    scanrst = 1'b0;
    step();
    step();
    scanrst = 1'b1;
    m_ptr = 0;
    m_rep = CNT_W'(1);
    m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_dur[i] = '0;
  endtask

  task automatic load(input bit ch, input logic [DATA_W-1:0] d);
    scanload = 1'b1;
    scanchoice = ch;
    datain = d;
    step();
    scanload = 1'b0;
    if (ch) m_rep = CNT_W'(d);
    else if (m_ptr == 2 * DEPTH) m_err = 1'b1;
    else begin
      if (m_ptr % 2 == 0) m_dur[m_ptr/2] = d;
      else m_pat[m_ptr/2] = d[PAT_W-1:0];
      m_ptr++;
    end
  endtask

  task automatic clr();
    tbl_clr = 1'b1;
    step();
    tbl_clr = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < DEPTH; i++) m_dur[i] = '0;
  endtask

  // Expand the table into one expected pattern per clock; continuous mode gets three scans.
  task automatic build_trace();
    int nscan;
    logic [PAT_W-1:0] p;
    logic [NCH-1:0] src, dst;
    trace.delete();
    scan_len = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_dur[i] == 0) break;
      scan_len += int'(m_dur[i]);
    end
    nscan = (m_rep == 0) ? 3 : int'(m_rep);
    for (int s = 0; s < nscan; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_dur[i] == 0) break;
        p = m_pat[i];
        src = p[PAT_W-1:7];
        dst = src;
`ifdef SCAN_ALT_ACQ_EN
        for (int b = 0; b < NCH; b++) dst[(b + s) % NCH] = src[b];
`endif
        p = {dst, p[6:0]};
        for (int c = 0; c < int'(m_dur[i]); c++) trace.push_back(p);
      end
    end
  endtask

  task automatic run_check(input int abort_at, input bit poke, input bit hold);
    bit done;
    done = 1'b0;
    build_trace();
    scanstart = 1'b1;
    step();
    if (!hold) scanstart = 1'b0;
    for (int k = 0; k <= trace.size(); k++) begin
      if (abort_at >= 0 && k == abort_at + 1) begin
        checks++;
        if (obs !== '0 || busy !== 1'b0 || interrupt !== 1'b0 ||
            scan_cnt !== CNT_W'(abort_at / scan_len)) begin
          errors++;
          $display("FAIL abort k=%0d: obs=%h busy=%b irq=%b cnt=%0d, expected 0 0 0 %0d",
                   k, obs, busy, interrupt, scan_cnt, abort_at / scan_len);
        end
        scanabort = 1'b0;
        break;
      end
      if (k == trace.size()) begin
        checks++;
        if (obs !== '0 || busy !== 1'b0 || interrupt !== 1'b1 || scan_cnt !== m_rep) begin
          errors++;
          $display("FAIL completion at E0+%0d: obs=%h busy=%b irq=%b cnt=%0d, expected 0 0 1 %0d",
                   k, obs, busy, interrupt, scan_cnt, m_rep);
        end
        done = 1'b1;
      end else begin
        checks++;
        if (obs !== trace[k] || busy !== 1'b1 || interrupt !== 1'b0 ||
            scan_cnt !== CNT_W'(k / scan_len)) begin
          errors++;
          $display("FAIL run cycle %0d: obs=%h busy=%b irq=%b cnt=%0d, expected %h 1 0 %0d",
                   k, obs, busy, interrupt, scan_cnt, trace[k], k / scan_len);
        end
      end
      if (poke && k == 1) begin
        scanload = 1'b1; scanchoice = 1'b1; datain = DATA_W'(7); m_err = 1'b1;
      end
      if (poke && k == 2) begin
        scanload = 1'b0; tbl_clr = 1'b1;
      end
      if (poke && k == 3) tbl_clr = 1'b0;
      if (k == abort_at) scanabort = 1'b1;
      if (k < trace.size()) step();
    end
    if (done) begin
      for (int j = 0; j < (hold ? 3 : 1); j++) begin
        step();
        checks++;
        if (interrupt !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL post_done+%0d: irq=%b busy=%b, expected 0 0", j + 1, interrupt, busy);
        end
      end
    end
    scanstart = 1'b0;
    step();
  endtask

  task automatic check_err(input string name);
    checks++;
    if (load_err !== m_err) begin
      errors++;
      $display("FAIL %s load_err: got %b expected %b", name, load_err, m_err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== '0 || busy !== 1'b0 || interrupt !== 1'b0 || scan_cnt !== '0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: obs=%h busy=%b irq=%b cnt=%0d err=%b, expected all 0",
               obs, busy, interrupt, scan_cnt, load_err);
    end
  endtask

  task automatic test_empty_start();
    scanstart = 1'b1;
    step();
    scanstart = 1'b0;
    m_err = 1'b1;
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL empty_start busy: got %b expected 0", busy);
      end
      step();
    end
    check_err("empty_start");
  endtask

  task automatic load_basic();
    load(1'b0, DATA_W'(5)); load(1'b0, DATA_W'('h01));
    load(1'b0, DATA_W'(3)); load(1'b0, DATA_W'('h20));
    load(1'b0, DATA_W'(0));
    load(1'b1, DATA_W'(2));
  endtask

  task automatic test_basic();
    do_reset();
    load_basic();
    run_check(-1, 1'b0, 1'b0);
    check_err("basic");
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      load(1'b0, DATA_W'(1));
      load(1'b0, DATA_W'(((i + 1) * 37) % 512));
    end
    load(1'b1, DATA_W'(1));
    check_err("full_before");
    run_check(-1, 1'b0, 1'b0);
    load(1'b0, DATA_W'(1));
    check_err("full_overflow");
  endtask

  task automatic test_abort();
    do_reset();
    load(1'b0, DATA_W'(2)); load(1'b0, DATA_W'('h03));
    load(1'b0, DATA_W'(2)); load(1'b0, DATA_W'('h140));
    load(1'b1, DATA_W'(0));
    run_check(10, 1'b0, 1'b0);
    scanabort = 1'b1;
    scanstart = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || obs !== '0) begin
      errors++;
      $display("FAIL abort_vs_start: busy=%b obs=%h expected 0 0", busy, obs);
    end
    scanabort = 1'b0;
    scanstart = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || interrupt !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: busy=%b irq=%b expected 0 0", busy, interrupt);
    end
  endtask

  task automatic test_busy_writes();
    do_reset();
    load_basic();
    run_check(-1, 1'b1, 1'b0);
    check_err("busy_writes");
    run_check(-1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      clr();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        load(1'b0, DATA_W'($urandom_range(1, 4)));
        load(1'b0, DATA_W'($urandom % 512));
      end
      if (n < DEPTH && ($urandom % 2) == 1) load(1'b0, DATA_W'(0));
      load(1'b1, DATA_W'($urandom_range(1, 3)));
      run_check(-1, 1'b0, 1'b0);
    end
    check_err("random");
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(1'b0, DATA_W'(10));
    load(1'b0, DATA_W'('h1FF));
    scanstart = 1'b1;
    step();
    scanstart = 1'b0;
    step(); step(); step();
    checks++;
    if (obs !== 9'h1FF || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run: obs=%h busy=%b expected 1ff 1", obs, busy);
    end
    scanrst = 1'b0;
    step();
    checks++;
    if (obs !== '0 || busy !== 1'b0 || scan_cnt !== '0 || interrupt !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: obs=%h busy=%b cnt=%0d irq=%b expected 0 0 0 0",
               obs, busy, scan_cnt, interrupt);
    end
    scanrst = 1'b1;
    m_ptr = 0; m_rep = CNT_W'(1); m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_dur[i] = '0;
    step();
    test_empty_start();
  endtask

  initial begin
    scanrst = 1'b0; scanstart = 1'b0; scanabort = 1'b0;
    scanload = 1'b0; scanchoice = 1'b0; tbl_clr = 1'b0; datain = '0;
    test_reset();
    test_empty_start();
    test_basic();
    test_full();
    test_abort();
    test_busy_writes();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
